// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a DIGITS-wide 7-segment display.
// Updates are staged in a pending register and committed only when the scan
// wraps to digit 0, so a frame never shows a mix of old and new data.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  pending
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   tick;
    logic                   wrap;

    logic [4*DIGITS-1:0]    sh_data;
    logic [DIGITS-1:0]      sh_dp;
    logic [DIGITS-1:0]      sh_blank;
    logic [4*DIGITS-1:0]    pd_data;
    logic [DIGITS-1:0]      pd_dp;
    logic [DIGITS-1:0]      pd_blank;
    logic                   valid;

    logic [DIGITS-1:0]      dark;
    logic [DIGITS-1:0]      sel;
    logic [3:0]             nib;

    assign tick    = (cnt == CW'(SCAN_DIV - 1));
    assign wrap    = tick && (idx == IW'(DIGITS - 1));
    assign pending = valid;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Prescaler: counts 0..SCAN_DIV-1, one tick per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Digit index: advances on each tick, wraps to 0 after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     idx <= '0;
        else if (wrap)  idx <= '0;
        else if (tick)  idx <= idx + 1'b1;
    end

    // Staging and commit: a load in the wrap cycle bypasses straight to shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            pd_data  <= '0;
            pd_dp    <= '0;
            pd_blank <= '0;
            valid    <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp;
                sh_blank <= blank;
            end else if (valid) begin
                sh_data  <= pd_data;
                sh_dp    <= pd_dp;
                sh_blank <= pd_blank;
            end
            valid <= 1'b0;
        end else if (load) begin
            pd_data  <= data;
            pd_dp    <= dp;
            pd_blank <= blank;
            valid    <= 1'b1;
        end
    end

    // Effective dark mask: explicit blanks, plus leading zeros when enabled.
    always_comb begin
        dark = sh_blank;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lzb
            logic run;
            run = 1'b1;
            for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
                run = run && (sh_data[4*i +: 4] == 4'h0);
                if (run) dark[i] = 1'b1;
            end
        end
`endif
    end

    // Current digit select and nibble.
    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
        nib      = sh_data[4*int'(idx) +: 4];
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= '0;
            an    <= '0;
            frame <= 1'b0;
        end else begin
            frame <= wrap;
            if (dark[idx]) begin
                seg <= '0;
                an  <= '0;
            end else begin
                seg <= {sh_dp[idx], hex7(nib)};
                an  <= sel;
            end
        end
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

- Time-multiplexed driver for a DIGITS-wide common-anode-select 7-segment display.
- Accepts a packed hex word plus decimal-point and blank masks. Decodes one digit per scan slot and drives the one-hot digit select in rotation.
- New data is staged and committed only at frame boundaries, so a display update never tears mid-frame.
- Sits between the datapath/status registers and the board's segment/anode pins. It is the clocked, multi-digit successor of the single-digit combinational decoder.

## Interface
- DIGITS, 4: number of digits. Legal range 1..8.
- SCAN_DIV, 1000: clock cycles per digit slot. Must be ≥2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data  input  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is the rightmost / least significant.
- dp  input  DIGITS  decimal point per digit, 1 = lit.
- blank  input  DIGITS  per-digit blank, 1 = digit dark.
- load  input  1  capture data/dp/blank into the pending register this cycle.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
- an  output  DIGITS  one-hot digit enable, active-high, registered.
- frame  output  1  one-cycle pulse when the scan wraps to digit 0.
- pending  output  1  1 while a captured update awaits commit.

## Operation
- **Prescaler.** Counts 0..SCAN_DIV-1. A tick is asserted in the cycle the prescaler equals SCAN_DIV-1; the prescaler then wraps to 0.
- **Digit index.**
  - On a tick, idx increments.
  - At DIGITS-1 it wraps to 0; at the wrap, commit and frame occur.
  - With DIGITS=1, every tick is a wrap.
- **Registers.** Shadow {data,dp,blank} drives the display. The pending register plus a valid flag stage updates.
- **load.**
  - Copies inputs into pending and sets valid.
  - A second load before commit overwrites pending; only the last load is committed.
- **Commit at wrap.**
  - If valid, shadow ← pending and valid clears.
  - If load is asserted in the wrap cycle itself, the inputs of that cycle go straight into shadow and valid is cleared (bypass; the newest value wins).
- **Decode, active-high hex.** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg[7] = dp of the current digit.
- **Blanked digit.** an bit for that slot = 0 and seg = 8'h00. The slot time is still spent.
- **Outputs.** an = one-hot(idx) and seg = decode(shadow digit idx). Both are registered, so they reflect idx and shadow from the previous cycle.

## Timing
- **Reset values.**
  - prescaler=0, idx=0.
  - shadow data=0, dp=0, blank=all ones (display dark).
  - pending register=0, valid=0.
  - seg=8'h00, an=0, frame=0, pending=0.
- **After reset release.**
  - First clock edge: an=0 and seg=0, because everything is blanked.
  - First wrap: idx goes DIGITS-1→0 at the end of cycle DIGITS*SCAN_DIV-1 counted from the first post-reset edge.
- **Slot length.** Each digit is held for exactly SCAN_DIV cycles. A frame is DIGITS*SCAN_DIV cycles.
- **Update latency.**
  - From the load edge to the committed value: at most one frame.
  - A committed value appears on seg/an one cycle after the wrap edge, on digit 0.
- **frame.** High for exactly the one cycle after each wrap edge, aligned with an switching to digit 0.
- **pending.** Rises the cycle after a load edge and falls the cycle after the commit edge. It stays 0 for a bypass load.
- **Reset mid-frame.** All state returns asynchronously to the reset values. A staged update is discarded.
- **Inputs.** data, dp and blank are sampled only when load=1; they are don't-care otherwise.

## Configuration
- **LEADING_ZERO_BLANK_EN defined.**
  - Scanning from digit DIGITS-1 downward, every digit whose nibble is 0 is treated as blanked while all higher digits are also 0 or suppressed. The suppressed digit's dp is dark too.
  - Digit 0 is never suppressed by this rule.
  - Suppression is computed from shadow, so it changes only at commit.
- **Macro undefined.** Zero nibbles display "0" (3F) unless blank is set.

## Test plan
All scenarios use DIGITS=4 and SCAN_DIV=4.
- **Reset.** Hold rst_n=0, release, run 20 cycles → seg=00, an=0, frame pulses at cycle 16, pending=0.
- **Basic load.** Load data=16'h12AF, dp=0, blank=0 at cycle 2 → pending=1 until wrap. The next frame shows an=0001 seg=71, 0010 seg=77, 0100 seg=5B, 1000 seg=06, each for 4 cycles.
- **Overwrite.** Load 16'h1111, then 16'h2222 two cycles later, before the wrap → only 2222 is displayed (seg=5B on all digits); 1111 never appears.
- **Bypass.** Load 16'h0008 with dp=4'b0010 in the wrap cycle → digit 0 shows seg=7F in the next cycle, digit 1 shows seg=BF, pending stays 0.
- **Blank and dp.** blank=4'b0100, dp=4'b1000, data=16'h8888 → slot 2 gives an=0, seg=00; slot 3 gives seg=FF.
- **Leading-zero suppression (LEADING_ZERO_BLANK_EN defined).** data=16'h0050 → digits 3 and 2 are dark, digit 1 shows 6D, digit 0 shows 3F. data=16'h0000 → only digit 0 shows 3F. Without the macro, 16'h0050 shows 3F,3F,6D,3F on digits 3,2,1,0.
